// File: rtl/wbu.sv
// Write-back unit: retires one EXU instruction at a time into the GPR write port,
// waiting on the LSU for loads. Define YSYX_23060251_WBU_FWD_EN for decode-bypass ports.
module wbu #(
    parameter int XLEN = 32,
    parameter int RS_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            e_valid_i,
    output logic            e_ready_o,
    input  logic            e_wen_i,
    input  logic [RS_W-1:0] e_rd_i,
    input  logic [XLEN-1:0] e_wdata_i,
    input  logic            e_is_load_i,
    input  logic [2:0]      e_funct3_i,
    input  logic [1:0]      e_addr_lo_i,
    input  logic            m_rvalid_i,
    input  logic [XLEN-1:0] m_rdata_i,
    output logic            m_rready_o,
    output logic            wen_o,
    output logic [RS_W-1:0] rd_o,
    output logic [XLEN-1:0] e_wdata_o,
    output logic            is_load_o,
    output logic [XLEN-1:0] m_wdata_o,
    output logic            commit_o,
`ifdef YSYX_23060251_WBU_FWD_EN
    output logic            fwd_valid_o,
    output logic [RS_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o,
`endif
    output logic            err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t            state_q, state_d;
    logic [RS_W-1:0]   rd_q;
    logic              wen_q;
    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [XLEN-1:0]   e_wdata_q;
    logic [XLEN-1:0]   m_wdata_q;
    logic              err_q;

    logic              accept;
    logic              fmt_err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   ext;

    assign e_ready_o  = (state_q != WAIT_MEM);
    assign m_rready_o = (state_q == WAIT_MEM);
    assign accept     = e_valid_i & e_ready_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: begin
                if (accept)
                    state_d = e_is_load_i ? WAIT_MEM : WRITE;
                else
                    state_d = IDLE;
            end
            WAIT_MEM: if (m_rvalid_i) state_d = WRITE;
            default:  state_d = IDLE;
        endcase
    end

    // Misaligned or undefined load formats still complete; they only flag err_o.
    always_comb begin
        fmt_err = 1'b0;
        case (e_funct3_i)
            3'b000, 3'b100: fmt_err = 1'b0;
            3'b001, 3'b101: fmt_err = e_addr_lo_i[0];
            3'b010:         fmt_err = (e_addr_lo_i != 2'b00);
            default:        fmt_err = 1'b1;
        endcase
    end

    assign byte_sel = m_rdata_i[{addr_lo_q, 3'b000} +: 8];
    assign half_sel = m_rdata_i[{addr_lo_q[1], 4'b0000} +: 16];

    always_comb begin
        ext = m_rdata_i;
        case (funct3_q)
            3'b000:  ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  ext = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  ext = {{(XLEN-16){1'b0}}, half_sel};
            default: ext = m_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            is_load_q <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            e_wdata_q <= '0;
            m_wdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q      <= e_rd_i;
                is_load_q <= e_is_load_i;
                if (e_is_load_i) begin
                    wen_q     <= 1'b1;
                    funct3_q  <= e_funct3_i;
                    addr_lo_q <= e_addr_lo_i;
                end else begin
                    wen_q     <= e_wen_i;
                    e_wdata_q <= e_wdata_i;
                end
            end
            if (state_q == WAIT_MEM && m_rvalid_i)
                m_wdata_q <= ext;
            if ((m_rvalid_i && state_q != WAIT_MEM) || (accept && e_is_load_i && fmt_err))
                err_q <= 1'b1;
        end
    end

    assign commit_o  = (state_q == WRITE);
    assign wen_o     = commit_o & wen_q & (rd_q != '0);
    assign is_load_o = commit_o & is_load_q;
    assign rd_o      = rd_q;
    assign e_wdata_o = e_wdata_q;
    assign m_wdata_o = m_wdata_q;
    assign err_o     = err_q;

`ifdef YSYX_23060251_WBU_FWD_EN
    assign fwd_valid_o = wen_o;
    assign fwd_rd_o    = rd_q;
    assign fwd_data_o  = is_load_o ? m_wdata_q : e_wdata_q;
`endif

endmodule

// File: tb/tb_wbu.sv
// Directed scoreboard bench for wbu: stimulus pushes expected writes, a monitor
// pops and compares on every commit.
module tb_wbu;

    localparam int XLEN = 32;
    localparam int RS_W = 5;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            e_valid_i = 1'b0;
    logic            e_ready_o;
    logic            e_wen_i = 1'b0;
    logic [RS_W-1:0] e_rd_i = '0;
    logic [XLEN-1:0] e_wdata_i = '0;
    logic            e_is_load_i = 1'b0;
    logic [2:0]      e_funct3_i = 3'b000;
    logic [1:0]      e_addr_lo_i = 2'b00;
    logic            m_rvalid_i = 1'b0;
    logic [XLEN-1:0] m_rdata_i = '0;
    logic            m_rready_o;
    logic            wen_o;
    logic [RS_W-1:0] rd_o;
    logic [XLEN-1:0] e_wdata_o;
    logic            is_load_o;
    logic [XLEN-1:0] m_wdata_o;
    logic            commit_o;
    logic            err_o;

    wbu #(.XLEN(XLEN), .RS_W(RS_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .e_valid_i(e_valid_i), .e_ready_o(e_ready_o), .e_wen_i(e_wen_i),
        .e_rd_i(e_rd_i), .e_wdata_i(e_wdata_i), .e_is_load_i(e_is_load_i),
        .e_funct3_i(e_funct3_i), .e_addr_lo_i(e_addr_lo_i),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .m_rready_o(m_rready_o),
        .wen_o(wen_o), .rd_o(rd_o), .e_wdata_o(e_wdata_o), .is_load_o(is_load_o),
        .m_wdata_o(m_wdata_o), .commit_o(commit_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            wen;
        logic [RS_W-1:0] rd;
        logic            is_load;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every commit must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_i && (commit_o || wen_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", {31'd0, commit_o}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit", {31'd0, commit_o}, 32'd1);
                check("wen", {31'd0, wen_o}, {31'd0, e.wen});
                check("rd", {27'd0, rd_o}, {27'd0, e.rd});
                check("is_load", {31'd0, is_load_o}, {31'd0, e.is_load});
                if (e.is_load) check("m_wdata", m_wdata_o, e.data);
                else           check("e_wdata", e_wdata_o, e.data);
            end
        end
    end

    task automatic push(input logic wen, input logic [RS_W-1:0] rd, input logic ld, input logic [XLEN-1:0] d);
        exp_t e;
        e.wen = wen; e.rd = rd; e.is_load = ld; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic ld, input logic wen, input logic [RS_W-1:0] rd,
                         input logic [XLEN-1:0] d, input logic [2:0] f3, input logic [1:0] alo,
                         output int waits);
        logic acc;
        waits = 0;
        e_valid_i = 1'b1; e_is_load_i = ld; e_wen_i = wen; e_rd_i = rd;
        e_wdata_i = d; e_funct3_i = f3; e_addr_lo_i = alo;
        forever begin
            acc = e_ready_o;
            @(posedge clk_i);
            if (acc) break;
            waits++;
            if (waits > 50) begin
                check("issue_timeout", 32'd1, 32'd0);
                break;
            end
        end
        #1 e_valid_i = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [XLEN-1:0] d);
        logic acc;
        int   n;
        n = 0;
        repeat (delay) @(posedge clk_i);
        #1 m_rvalid_i = 1'b1; m_rdata_i = d;
        forever begin
            acc = m_rready_o;
            @(posedge clk_i);
            if (acc) break;
            n++;
            if (n > 50) begin
                check("rvalid_timeout", 32'd1, 32'd0);
                break;
            end
        end
        #1 m_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("load_wb_latency", {31'd0, commit_o}, 32'd1);
    endtask

    initial begin
        int w;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_e_ready", {31'd0, e_ready_o}, 32'd1);
        check("rst_wen", {31'd0, wen_o}, 32'd0);
        check("rst_commit", {31'd0, commit_o}, 32'd0);
        check("rst_m_rready", {31'd0, m_rready_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_m_wdata", m_wdata_o, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // single ALU write
        push(1'b1, 5'd5, 1'b0, 32'h0000_1234);
        issue(1'b0, 1'b1, 5'd5, 32'h0000_1234, 3'b000, 2'b00, w);
        @(negedge clk_i);

        // three back-to-back ALU instrs, no stall expected
        push(1'b1, 5'd1, 1'b0, 32'hAAAA_0001);
        push(1'b1, 5'd2, 1'b0, 32'hBBBB_0002);
        push(1'b1, 5'd3, 1'b0, 32'hCCCC_0003);
        issue(1'b0, 1'b1, 5'd1, 32'hAAAA_0001, 3'b000, 2'b00, w);
        check("b2b_stall0", w, 0);
        issue(1'b0, 1'b1, 5'd2, 32'hBBBB_0002, 3'b000, 2'b00, w);
        check("b2b_stall1", w, 0);
        issue(1'b0, 1'b1, 5'd3, 32'hCCCC_0003, 3'b000, 2'b00, w);
        check("b2b_stall2", w, 0);
        @(negedge clk_i);

        // lb, lane 3, 4-cycle memory delay
        push(1'b1, 5'd10, 1'b1, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 5'd10, 32'h0, 3'b000, 2'b11, w);
        check("wait_e_ready", {31'd0, e_ready_o}, 32'd0);
        check("wait_m_rready", {31'd0, m_rready_o}, 32'd1);
        respond(4, 32'h80FF_FF00);

        push(1'b1, 5'd11, 1'b1, 32'h0000_BEEF);
        issue(1'b1, 1'b0, 5'd11, 32'h0, 3'b101, 2'b10, w);
        respond(1, 32'hBEEF_0000);
        push(1'b1, 5'd12, 1'b1, 32'hFFFF_BEEF);
        issue(1'b1, 1'b0, 5'd12, 32'h0, 3'b001, 2'b10, w);
        respond(0, 32'hBEEF_0000);
        push(1'b1, 5'd13, 1'b1, 32'h0000_0056);
        issue(1'b1, 1'b0, 5'd13, 32'h0, 3'b100, 2'b01, w);
        respond(2, 32'h1234_5678);
        push(1'b1, 5'd14, 1'b1, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 5'd14, 32'h0, 3'b010, 2'b00, w);
        respond(1, 32'hDEAD_BEEF);
        push(1'b1, 5'd15, 1'b1, 32'h0000_007F);
        issue(1'b1, 1'b0, 5'd15, 32'h0, 3'b000, 2'b00, w);
        respond(1, 32'h1234_567F);

        // rd==0 and e_wen==0 suppress the write but still commit
        push(1'b0, 5'd0, 1'b1, 32'h0000_1111);
        issue(1'b1, 1'b0, 5'd0, 32'h0, 3'b010, 2'b00, w);
        respond(3, 32'h0000_1111);
        push(1'b0, 5'd0, 1'b0, 32'h5555_5555);
        issue(1'b0, 1'b1, 5'd0, 32'h5555_5555, 3'b000, 2'b00, w);
        push(1'b0, 5'd9, 1'b0, 32'h6666_6666);
        issue(1'b0, 1'b0, 5'd9, 32'h6666_6666, 3'b000, 2'b00, w);
        repeat (2) @(negedge clk_i);
        check("err_clean", {31'd0, err_o}, 32'd0);

        // stray read data in IDLE
        @(posedge clk_i); #1 m_rvalid_i = 1'b1; m_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1 m_rvalid_i = 1'b0;
        check("err_stray_rvalid", {31'd0, err_o}, 32'd1);

        // reset mid-load, then a late response
        rst_i = 1'b0; #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("err_after_rst", {31'd0, err_o}, 32'd0);
        issue(1'b1, 1'b0, 5'd7, 32'h0, 3'b010, 2'b00, w);
        @(posedge clk_i); #1 rst_i = 1'b0;
        #2;
        check("midrst_e_ready", {31'd0, e_ready_o}, 32'd1);
        check("midrst_wen", {31'd0, wen_o}, 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h0BAD_0BAD;
        @(posedge clk_i); #1 m_rvalid_i = 1'b0;
        check("late_rvalid_err", {31'd0, err_o}, 32'd1);
        check("late_rvalid_e_ready", {31'd0, e_ready_o}, 32'd1);

        // misaligned lh still uses halfword lane 0 and flags err
        rst_i = 1'b0; #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        push(1'b1, 5'd20, 1'b1, 32'hFFFF_8001);
        issue(1'b1, 1'b0, 5'd20, 32'h0, 3'b001, 2'b01, w);
        respond(1, 32'h1234_8001);
        check("misaligned_err", {31'd0, err_o}, 32'd1);

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(negedge clk_i);
                n++;
            end
        end
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
